// File: rtl/kmeans_pkg.sv
// Shared constants and FSM state type for the k=2, n=2 k-means block.
package kmeans_pkg;

  localparam int unsigned k_clusters               = 2;
  localparam int unsigned n_dims                   = 2;
  localparam int unsigned data_width               = 16;
  localparam int unsigned input_data_qty_bit_width = 8;
  localparam int unsigned iter_width               = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_UPDATE,
    S_WAIT_UPD,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/kmeans_addr_gen.sv
// Point address counter: zeroed by clr, steps while valid, wraps to 0 after the last point.
module kmeans_addr_gen
  import kmeans_pkg::*;
#(
  parameter int unsigned addr_width = 8,
  parameter int unsigned qty        = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en_next,
  output logic [addr_width-1:0] addr,
  output logic                  valid,
  output logic                  last
);

  localparam logic [addr_width-1:0] last_addr = addr_width'(qty - 1);

  logic [addr_width-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;

  // next address and registered valid (valid mirrors the STREAM state)
  always_comb begin
    addr_d  = addr_q;
    valid_d = en_next;
    if (clr) begin
      addr_d = '0;
    end else if (valid_q) begin
      addr_d = (addr_q == last_addr) ? '0 : addr_q + addr_width'(1);
    end
  end

  // address/valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign addr  = addr_q;
  assign valid = valid_q;
  assign last  = valid_q && (addr_q == last_addr);

endmodule

// File: rtl/kmeans_k2n2_ctrl.sv
// Iteration sequencer for the k=2, n=2 k-means datapath (clear, stream, drain, update, check).
module kmeans_k2n2_ctrl
  import kmeans_pkg::*;
#(
  parameter int unsigned input_data_qty_bit_width = 8,
  parameter int unsigned input_data_qty           = 256,
  parameter int unsigned pipe_latency             = 4,
  parameter int unsigned max_iter                 = 16,
  parameter int unsigned iter_width               = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic [input_data_qty_bit_width-1:0] rd_addr,
  output logic                                rd_valid,
  output logic                                acc_clr,
  output logic                                upd_start,
  input  logic                                upd_done,
  input  logic                                centroids_changed,
  output logic                                busy,
  output logic                                done,
  output logic                                converged,
  output logic [iter_width-1:0]               iter_count
);

  localparam int unsigned drain_width = (pipe_latency > 1) ? $clog2(pipe_latency) : 1;
  localparam logic [drain_width-1:0] drain_load = drain_width'(pipe_latency - 1);
  localparam logic [iter_width-1:0]  iter_cap   = iter_width'(max_iter);

  state_t                 state_q, state_d;
  logic [drain_width-1:0] drain_q, drain_d;
  logic [iter_width-1:0]  iter_q, iter_d;
  logic                   changed_q, changed_d;
  logic                   converged_q, converged_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   acc_clr_q, acc_clr_d;
  logic                   upd_start_q, upd_start_d;
  logic                   addr_last;

  kmeans_addr_gen #(
    .addr_width (input_data_qty_bit_width),
    .qty        (input_data_qty)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == S_CLEAR),
    .en_next (state_d == S_STREAM),
    .addr    (rd_addr),
    .valid   (rd_valid),
    .last    (addr_last)
  );

  // next state, counters and registered-output values
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    iter_d      = iter_q;
    changed_d   = changed_q;
    converged_d = converged_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          iter_d  = '0;
        end
      end
      S_CLEAR:  state_d = S_STREAM;
      S_STREAM: begin
        if (addr_last) begin
          state_d = S_DRAIN;
          drain_d = drain_load;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_UPDATE;
        else               drain_d = drain_q - drain_width'(1);
      end
      S_UPDATE: state_d = S_WAIT_UPD;
      S_WAIT_UPD: begin
        if (upd_done) begin
          changed_d = centroids_changed;
          iter_d    = iter_q + iter_width'(1);
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!changed_q) begin
          state_d     = S_DONE;
          converged_d = 1'b1;
        end else if (iter_q == iter_cap) begin
          state_d     = S_DONE;
          converged_d = 1'b0;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d     = S_CLEAR;
          iter_d      = '0;
          converged_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    acc_clr_d   = (state_d == S_CLEAR);
    upd_start_d = (state_d == S_UPDATE);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      iter_q      <= '0;
      changed_q   <= 1'b0;
      converged_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      acc_clr_q   <= 1'b0;
      upd_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      iter_q      <= iter_d;
      changed_q   <= changed_d;
      converged_q <= converged_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      acc_clr_q   <= acc_clr_d;
      upd_start_q <= upd_start_d;
    end
  end

  assign acc_clr    = acc_clr_q;
  assign upd_start  = upd_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = converged_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_kmeans_k2n2_ctrl.sv
// Directed bench for kmeans_k2n2_ctrl with an address scoreboard.
module tb_kmeans_k2n2_ctrl;

  localparam int unsigned AW    = 2;
  localparam int unsigned QTY   = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned MAXIT = 3;
  localparam int unsigned IW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          upd_done = 1'b0;
  logic          centroids_changed = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          acc_clr;
  logic          upd_start;
  logic          busy;
  logic          done;
  logic          converged;
  logic [IW-1:0] iter_count;

  int checks = 0;
  int errors = 0;
  int n_clr  = 0;
  int n_upd  = 0;
  int base_clr;
  int base_upd;
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  kmeans_k2n2_ctrl #(
    .input_data_qty_bit_width (AW),
    .input_data_qty           (QTY),
    .pipe_latency             (LAT),
    .max_iter                 (MAXIT),
    .iter_width               (IW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .rd_addr           (rd_addr),
    .rd_valid          (rd_valid),
    .acc_clr           (acc_clr),
    .upd_start         (upd_start),
    .upd_done          (upd_done),
    .centroids_changed (centroids_changed),
    .busy              (busy),
    .done              (done),
    .converged         (converged),
    .iter_count        (iter_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every valid address must match the next expected one
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_extra_valid", 32'(rd_valid), 32'(0));
      else                   chk("sb_addr", 32'(rd_addr), 32'(exp_q.pop_front()));
    end
    if (acc_clr === 1'b1)   n_clr++;
    if (upd_start === 1'b1) n_upd++;
  end

  // Entered in the CLEAR cycle; returns in the cycle after CHECK.
  task automatic do_iter(input bit chg, input int wait_cyc, input int exp_iter, input bit stray);
    start = 1'b0;
    upd_done = 1'b0;
    chk("clr_acc_clr", 32'(acc_clr), 32'(1));
    chk("clr_busy", 32'(busy), 32'(1));
    chk("clr_rd_valid", 32'(rd_valid), 32'(0));
    chk("clr_done", 32'(done), 32'(0));
    chk("clr_converged", 32'(converged), 32'(0));
    chk("clr_iter", 32'(iter_count), 32'(exp_iter - 1));
    for (int i = 0; i < int'(QTY); i++) exp_q.push_back(AW'(i));
    for (int i = 0; i < int'(QTY); i++) begin
      step();
      chk("stream_valid", 32'(rd_valid), 32'(1));
      chk("stream_acc_clr", 32'(acc_clr), 32'(0));
      start    = (stray && i == 1);
      upd_done = (stray && i == 1);
    end
    for (int d = 0; d < int'(LAT); d++) begin
      step();
      chk("drain_valid", 32'(rd_valid), 32'(0));
      chk("drain_addr", 32'(rd_addr), 32'(0));
      chk("drain_upd_start", 32'(upd_start), 32'(0));
      chk("drain_busy", 32'(busy), 32'(1));
      start    = (stray && d == 0);
      upd_done = (stray && d == 0);
    end
    step();
    start = 1'b0;
    upd_done = 1'b0;
    chk("update_upd_start", 32'(upd_start), 32'(1));
    for (int w = 0; w < wait_cyc; w++) begin
      step();
      chk("wait_upd_start", 32'(upd_start), 32'(0));
      chk("wait_busy", 32'(busy), 32'(1));
      chk("wait_iter", 32'(iter_count), 32'(exp_iter - 1));
    end
    step();
    upd_done = 1'b1;
    centroids_changed = chg;
    step();
    upd_done = 1'b0;
    centroids_changed = ~chg;
    chk("check_iter", 32'(iter_count), 32'(exp_iter));
    chk("check_busy", 32'(busy), 32'(1));
    chk("check_done", 32'(done), 32'(0));
    step();
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst_addr", 32'(rd_addr), 32'(0));
    chk("rst_valid", 32'(rd_valid), 32'(0));
    chk("rst_acc_clr", 32'(acc_clr), 32'(0));
    chk("rst_upd_start", 32'(upd_start), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_converged", 32'(converged), 32'(0));
    chk("rst_iter", 32'(iter_count), 32'(0));
    rst = 1'b0;
    step();

    // first run: stray pulses, converges on iteration 1, then holds
    start = 1'b1;
    step();
    do_iter(1'b0, 3, 1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      chk("hold_done", 32'(done), 32'(1));
      chk("hold_converged", 32'(converged), 32'(1));
      chk("hold_busy", 32'(busy), 32'(0));
      chk("hold_iter", 32'(iter_count), 32'(1));
      step();
    end

    // restart from DONE, always changing: stop on cap
    base_clr = n_clr;
    base_upd = n_upd;
    start = 1'b1;
    step();
    do_iter(1'b1, 0, 1, 1'b0);
    do_iter(1'b1, 2, 2, 1'b0);
    do_iter(1'b1, 0, 3, 1'b0);
    chk("cap_done", 32'(done), 32'(1));
    chk("cap_converged", 32'(converged), 32'(0));
    chk("cap_iter", 32'(iter_count), 32'(3));
    chk("cap_busy", 32'(busy), 32'(0));
    chk("cap_n_acc_clr", 32'(n_clr - base_clr), 32'(3));
    chk("cap_n_upd_start", 32'(n_upd - base_upd), 32'(3));

    // no-change on the capped iteration: converged wins
    start = 1'b1;
    step();
    do_iter(1'b1, 0, 1, 1'b0);
    do_iter(1'b1, 1, 2, 1'b0);
    do_iter(1'b0, 0, 3, 1'b0);
    chk("tie_done", 32'(done), 32'(1));
    chk("tie_converged", 32'(converged), 32'(1));
    chk("tie_iter", 32'(iter_count), 32'(3));

    // async reset mid-stream at rd_addr == 2
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < int'(QTY); i++) exp_q.push_back(AW'(i));
    step();
    step();
    step();
    chk("mid_addr", 32'(rd_addr), 32'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_addr", 32'(rd_addr), 32'(0));
    chk("arst_valid", 32'(rd_valid), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_converged", 32'(converged), 32'(0));
    chk("arst_iter", 32'(iter_count), 32'(0));
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'(0));
    start = 1'b1;
    step();
    do_iter(1'b0, 1, 1, 1'b0);
    chk("post_rst_done", 32'(done), 32'(1));
    chk("post_rst_converged", 32'(converged), 32'(1));
    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
